// File: rtl/socetlib_counter_edge.sv
// Counter with terminal-count wrap, plus independent per-lane edge detectors.
// The two sections share only clock and reset.
module socetlib_counter_edge #(
    parameter int NBITS = 32,
    parameter int WIDTH = 1
) (
    input  logic             clk,
    input  logic             nrst,
    input  logic             clear,
    input  logic             count_enable,
    input  logic [NBITS-1:0] overflow_val,
    output logic [NBITS-1:0] count_out,
    output logic             overflow_flag,
    input  logic [WIDTH-1:0] signal,
    output logic [WIDTH-1:0] pos_edge,
    output logic [WIDTH-1:0] neg_edge
);

    logic [NBITS-1:0] r_count;
    logic [WIDTH-1:0] r_prev;
    logic             w_at_ovf;
    logic [NBITS-1:0] w_count_inc;

    assign w_at_ovf    = (r_count == overflow_val);
    assign w_count_inc = r_count + NBITS'(1);

    // Count register: clear wins, else advance and wrap at the terminal value
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            r_count <= '0;
        end else if (clear) begin
            r_count <= '0;
        end else if (count_enable) begin
            r_count <= w_at_ovf ? '0 : w_count_inc;
        end
    end

    // Previous-level register for every edge-detect lane
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            r_prev <= '0;
        end else begin
            r_prev <= signal;
        end
    end

    assign count_out     = r_count;
    assign overflow_flag = w_at_ovf;
    assign pos_edge      = signal & ~r_prev;
    assign neg_edge      = ~signal & r_prev;

endmodule

// File: tb/tb_socetlib_counter_edge.sv
// Directed bench for socetlib_counter_edge (NBITS=4, WIDTH=2).
// Expected values are written out by hand at each step.
module tb_socetlib_counter_edge;

    logic       clk;
    logic       nrst;
    logic       clear;
    logic       count_enable;
    logic [3:0] overflow_val;
    logic [3:0] count_out;
    logic       overflow_flag;
    logic [1:0] signal;
    logic [1:0] pos_edge;
    logic [1:0] neg_edge;

    int n_checks = 0;
    int n_errors = 0;

    socetlib_counter_edge #(
        .NBITS(4),
        .WIDTH(2)
    ) u_dut (
        .clk          (clk),
        .nrst         (nrst),
        .clear        (clear),
        .count_enable (count_enable),
        .overflow_val (overflow_val),
        .count_out    (count_out),
        .overflow_flag(overflow_flag),
        .signal       (signal),
        .pos_edge     (pos_edge),
        .neg_edge     (neg_edge)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_cnt(input string tag, input logic [3:0] exp_cnt,
                           input logic exp_flag);
        chk({tag, "_cnt"}, 32'(count_out), 32'(exp_cnt));
        chk({tag, "_flag"}, 32'(overflow_flag), 32'(exp_flag));
    endtask

    task automatic chk_edge(input string tag, input logic [1:0] exp_pos,
                            input logic [1:0] exp_neg);
        chk({tag, "_pos"}, 32'(pos_edge), 32'(exp_pos));
        chk({tag, "_neg"}, 32'(neg_edge), 32'(exp_neg));
    endtask

    initial begin
        logic [3:0] seq_exp [8];
        seq_exp[0] = 4'd1; seq_exp[1] = 4'd2; seq_exp[2] = 4'd3;
        seq_exp[3] = 4'd4; seq_exp[4] = 4'd5; seq_exp[5] = 4'd0;
        seq_exp[6] = 4'd1; seq_exp[7] = 4'd2;

        nrst         = 1'b0;
        clear        = 1'b0;
        count_enable = 1'b0;
        overflow_val = 4'd5;
        signal       = 2'b00;
        #1;
        chk_cnt("rst", 4'd0, 1'b0);
        chk_edge("rst_sig0", 2'b00, 2'b00);
        signal = 2'b11;
        #1;
        chk_edge("rst_sig1", 2'b11, 2'b00);
        overflow_val = 4'd0;
        #0.5;
        chk_cnt("rst_ovf0", 4'd0, 1'b1);
        signal       = 2'b00;
        overflow_val = 4'd5;
        count_enable = 1'b1;
        #0.5;
        nrst = 1'b1;

        for (int i = 0; i < 8; i++) begin
            step();
            chk_cnt($sformatf("wrap%0d", i), seq_exp[i], seq_exp[i] == 4'd5);
        end

        overflow_val = 4'hF;
        repeat (5) step();
        chk_cnt("to7", 4'd7, 1'b0);
        clear = 1'b1;
        step();
        chk_cnt("clr", 4'd0, 1'b0);
        clear = 1'b0;
        step();
        chk_cnt("clr_rel", 4'd1, 1'b0);

        repeat (2) step();
        chk_cnt("to3", 4'd3, 1'b0);
        count_enable = 1'b0;
        for (int i = 0; i < 4; i++) begin
            step();
            chk_cnt($sformatf("hold%0d", i), 4'd3, 1'b0);
        end

        count_enable = 1'b1;
        repeat (11) step();
        chk_cnt("toE", 4'hE, 1'b0);
        step();
        chk_cnt("allF", 4'hF, 1'b1);
        step();
        chk_cnt("allwrap", 4'h0, 1'b0);

        repeat (7) step();
        chk_cnt("to7b", 4'd7, 1'b0);
        overflow_val = 4'd3;
        step();
        chk_cnt("past_ovf8", 4'd8, 1'b0);
        repeat (7) step();
        chk_cnt("past_ovf15", 4'hF, 1'b0);
        step();
        chk_cnt("past_wrap", 4'd0, 1'b0);
        step();
        chk_cnt("past_1", 4'd1, 1'b0);
        step();
        chk_cnt("past_2", 4'd2, 1'b0);
        step();
        chk_cnt("hit_3", 4'd3, 1'b1);
        step();
        chk_cnt("hit_wrap", 4'd0, 1'b0);

        count_enable = 1'b0;
        signal = 2'b01;
        #1;
        chk_edge("e01", 2'b01, 2'b00);
        step();
        signal = 2'b11;
        #1;
        chk_edge("e11", 2'b10, 2'b00);
        step();
        signal = 2'b10;
        #1;
        chk_edge("e10", 2'b00, 2'b01);
        step();
        signal = 2'b00;
        #1;
        chk_edge("e00", 2'b00, 2'b10);
        step();
        chk_edge("e_settle", 2'b00, 2'b00);
        chk_cnt("indep", 4'd0, 1'b0);
        signal = 2'b10;
        step();
        step();
        chk_edge("e_held", 2'b00, 2'b00);
        signal = 2'b00;
        step();

        overflow_val = 4'hF;
        count_enable = 1'b1;
        repeat (9) step();
        chk_cnt("to9", 4'd9, 1'b0);
        #2;
        nrst   = 1'b0;
        signal = 2'b01;
        #1;
        chk_cnt("async", 4'd0, 1'b0);
        chk_edge("async_sig", 2'b01, 2'b00);
        step();
        chk_cnt("in_rst", 4'd0, 1'b0);
        chk_edge("in_rst_sig", 2'b01, 2'b00);
        count_enable = 1'b0;
        nrst = 1'b1;
        #1;
        chk_cnt("rel", 4'd0, 1'b0);
        step();
        chk_cnt("rel_edge", 4'd0, 1'b0);
        chk_edge("rel_prev", 2'b00, 2'b00);
        count_enable = 1'b1;
        step();
        chk_cnt("resume", 4'd1, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors",
                 n_checks, n_errors);
        $finish;
    end

endmodule
